softmc_host_bridge: RTL and testbench



---
 rtl/softmc_host_bridge.sv | 238 +++++++++++++++++++++++
 tb/tb_softmc_host_bridge.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmc_host_bridge.sv
// Host-side bridge for softMC: buffers host instructions into the app_en/app_ack handshake
// and merges both pseudo-channel read-back FIFOs into one tagged stream. Optional ack
// watchdog enabled by defining SOFTMC_BRIDGE_TIMEOUT_EN.
module softmc_host_bridge #(
  parameter int DQ_WIDTH    = 256,
  parameter int BUF_DEPTH   = 16,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       s_instr_valid,
  output logic                       s_instr_ready,
  input  logic [31:0]                s_instr_data,
  output logic                       app_en,
  input  logic                       app_ack,
  output logic [31:0]                app_instr,
  input  logic                       iq_full,
  input  logic                       rdback_fifo_empty_pc0,
  input  logic                       rdback_fifo_empty_pc1,
  input  logic [DQ_WIDTH-1:0]        rdback_data_pc0,
  input  logic [DQ_WIDTH-1:0]        rdback_data_pc1,
  output logic                       rdback_fifo_rd_en_pc0,
  output logic                       rdback_fifo_rd_en_pc1,
  output logic                       m_rd_valid,
  input  logic                       m_rd_ready,
  output logic [DQ_WIDTH-1:0]        m_rd_data,
  output logic                       m_rd_pc,
  output logic [$clog2(BUF_DEPTH):0] buf_count,
  output logic                       err_timeout
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("softmc_host_bridge: BUF_DEPTH must be a power of two >= 2");
  end
  if (ACK_TIMEOUT < 1) begin : g_bad_timeout
    $error("softmc_host_bridge: ACK_TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  logic [31:0]   mem_r [BUF_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_s;
  logic          empty_s;
  logic          ready_s;
  logic          push_s;
  logic          pop_s;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          app_en_r;
  logic          app_en_nxt_s;
  logic [31:0]   app_instr_r;
  logic [31:0]   app_instr_nxt_s;
  logic          to_expire_s;

  logic                rd_valid_r;
  logic [DQ_WIDTH-1:0] rd_data_r;
  logic                rd_pc_r;
  logic                rr_r;
  logic                load_s;
  logic                gnt0_s;
  logic                gnt1_s;

  // Ready uses the pre-pop count, so a full buffer refuses a push even while popping.
  assign full_s  = (count_r == DEPTH_C);
  assign empty_s = (count_r == {CW{1'b0}});
  assign ready_s = !full_s && (state_r != ST_ERR) && !srst;
  assign push_s  = s_instr_valid && ready_s;

  assign s_instr_ready = ready_s;
  assign buf_count     = count_r;
  assign app_en        = app_en_r;
  assign app_instr     = app_instr_r;

  // Instruction storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= s_instr_data;
    end
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sender next-state: launch from IDLE, hold the offer in SEND until ack or watchdog.
  always_comb begin
    state_nxt_s     = state_r;
    app_en_nxt_s    = app_en_r;
    app_instr_nxt_s = app_instr_r;
    pop_s           = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s && !iq_full) begin
          state_nxt_s     = ST_SEND;
          app_en_nxt_s    = 1'b1;
          app_instr_nxt_s = mem_r[rd_ptr_r];
        end else begin
          app_en_nxt_s    = 1'b0;
        end
      end
      ST_SEND: begin
        if (app_ack) begin
          pop_s        = 1'b1;
          app_en_nxt_s = 1'b0;
          state_nxt_s  = ST_IDLE;
        end else if (to_expire_s) begin
          app_en_nxt_s = 1'b0;
          state_nxt_s  = ST_ERR;
        end else begin
          app_en_nxt_s = 1'b1;
        end
      end
      ST_ERR: begin
        app_en_nxt_s = 1'b0;
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        app_en_nxt_s = 1'b0;
      end
    endcase
  end

  // Sender state and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_r     <= ST_IDLE;
      app_en_r    <= 1'b0;
      app_instr_r <= 32'h0000_0000;
    end else begin
      state_r     <= state_nxt_s;
      app_en_r    <= app_en_nxt_s;
      app_instr_r <= app_instr_nxt_s;
    end
  end

`ifdef SOFTMC_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

  logic [TW-1:0] to_cnt_r;
  logic          err_r;

  assign to_expire_s = (state_r == ST_SEND) && !app_ack && (to_cnt_r == TO_LAST);
  assign err_timeout = err_r;

  // Ack watchdog: counts unacknowledged SEND cycles; the error flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      to_cnt_r <= {TW{1'b0}};
      err_r    <= 1'b0;
    end else begin
      if (state_r == ST_SEND && !app_ack) to_cnt_r <= to_cnt_r + TW'(1);
      else                                 to_cnt_r <= {TW{1'b0}};
      if (to_expire_s) err_r <= 1'b1;
    end
  end
`else
  assign to_expire_s = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Read-back source select: round-robin only when both FIFOs hold data.
  assign load_s = !rd_valid_r || m_rd_ready;

  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (load_s && !srst) begin
      if (!rdback_fifo_empty_pc0 && !rdback_fifo_empty_pc1) begin
        if (rr_r) gnt1_s = 1'b1;
        else      gnt0_s = 1'b1;
      end else if (!rdback_fifo_empty_pc0) begin
        gnt0_s = 1'b1;
      end else if (!rdback_fifo_empty_pc1) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  assign rdback_fifo_rd_en_pc0 = gnt0_s;
  assign rdback_fifo_rd_en_pc1 = gnt1_s;
  assign m_rd_valid            = rd_valid_r;
  assign m_rd_data             = rd_data_r;
  assign m_rd_pc               = rd_pc_r;

  // Read-back output register.
  always_ff @(posedge clk) begin
    if (srst) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= {DQ_WIDTH{1'b0}};
      rd_pc_r    <= 1'b0;
      rr_r       <= 1'b0;
    end else if (load_s) begin
      rd_valid_r <= gnt0_s || gnt1_s;
      if (gnt0_s) begin
        rd_data_r <= rdback_data_pc0;
        rd_pc_r   <= 1'b0;
        rr_r      <= 1'b1;
      end else if (gnt1_s) begin
        rd_data_r <= rdback_data_pc1;
        rd_pc_r   <= 1'b1;
        rr_r      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_softmc_host_bridge.sv
// Directed self-checking bench for softmc_host_bridge; two small FWFT FIFO models feed
// the read-back side. Timeout checks follow SOFTMC_BRIDGE_TIMEOUT_EN.
module tb_softmc_host_bridge;

  logic         clk = 1'b0;
  logic         srst = 1'b1;
  logic         s_instr_valid = 1'b0;
  logic         s_instr_ready;
  logic [31:0]  s_instr_data = 32'h0;
  logic         app_en;
  logic         app_ack = 1'b0;
  logic [31:0]  app_instr;
  logic         iq_full = 1'b0;
  logic         empty0, empty1;
  logic [255:0] data0, data1;
  logic         rd_en0, rd_en1;
  logic         m_rd_valid;
  logic         m_rd_ready = 1'b0;
  logic [255:0] m_rd_data;
  logic         m_rd_pc;
  logic [4:0]   buf_count;
  logic         err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [255:0] arr0 [0:7];
  logic [255:0] arr1 [0:7];
  int lim0 = 0, lim1 = 0;
  int pop0 = 0, pop1 = 0;

  always #5 clk = ~clk;

  // FWFT FIFO models: absolute fill limits set by the stimulus, pop counters advanced by rd_en.
  always @(posedge clk) begin
    if (rd_en0) pop0 <= pop0 + 1;
    if (rd_en1) pop1 <= pop1 + 1;
  end
  assign empty0 = (pop0 >= lim0);
  assign empty1 = (pop1 >= lim1);
  assign data0  = arr0[pop0[2:0]];
  assign data1  = arr1[pop1[2:0]];

  softmc_host_bridge #(.DQ_WIDTH(256), .BUF_DEPTH(16), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .srst(srst),
    .s_instr_valid(s_instr_valid), .s_instr_ready(s_instr_ready), .s_instr_data(s_instr_data),
    .app_en(app_en), .app_ack(app_ack), .app_instr(app_instr), .iq_full(iq_full),
    .rdback_fifo_empty_pc0(empty0), .rdback_fifo_empty_pc1(empty1),
    .rdback_data_pc0(data0), .rdback_data_pc1(data1),
    .rdback_fifo_rd_en_pc0(rd_en0), .rdback_fifo_rd_en_pc1(rd_en1),
    .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready), .m_rd_data(m_rd_data), .m_rd_pc(m_rd_pc),
    .buf_count(buf_count), .err_timeout(err_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_app_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (app_en === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    srst = 1'b1;
    tick(); tick();
    n_tests++; if (app_en !== 1'b0) begin n_fail++; $display("FAIL reset_app_en: got %b want 0", app_en); end
    n_tests++; if (app_instr !== 32'h0) begin n_fail++; $display("FAIL reset_app_instr: got %h want 0", app_instr); end
    n_tests++; if (buf_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", buf_count); end
    n_tests++; if ({m_rd_valid, m_rd_pc} !== 2'b00) begin n_fail++; $display("FAIL reset_rd: got v=%b pc=%b want 0/0", m_rd_valid, m_rd_pc); end
    n_tests++; if (m_rd_data !== 256'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", m_rd_data); end
    n_tests++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_timeout); end
    n_tests++; if (s_instr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_reset: got %b want 0", s_instr_ready); end
    srst = 1'b0;
    #1;
    n_tests++; if (s_instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b want 1", s_instr_ready); end
  endtask

  task automatic test_send_three();
    logic [31:0] w [3];
    bit ok;
    w[0] = 32'h1111_1111; w[1] = 32'h2222_2222; w[2] = 32'h3333_3333;
    for (int i = 0; i < 3; i++) begin
      s_instr_valid = 1'b1; s_instr_data = w[i];
      tick();
    end
    s_instr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_app_en(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL send3_wait: app_en never rose for word %0d", k); end
      n_tests++; if (app_instr !== w[k]) begin n_fail++; $display("FAIL send3_instr: got %h want %h", app_instr, w[k]); end
      tick();
      n_tests++; if ({app_en, app_instr} !== {1'b1, w[k]}) begin n_fail++; $display("FAIL send3_hold: got en=%b %h want 1 %h", app_en, app_instr, w[k]); end
      app_ack = 1'b1; tick(); app_ack = 1'b0;
      n_tests++; if (app_en !== 1'b0) begin n_fail++; $display("FAIL send3_drop: got %b want 0", app_en); end
    end
    n_tests++; if (buf_count !== 5'd0) begin n_fail++; $display("FAIL send3_count: got %0d want 0", buf_count); end
  endtask

  task automatic test_iq_full();
    bit ok;
    iq_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_instr_valid = 1'b1; s_instr_data = 32'h50 + 32'(i);
      tick();
    end
    s_instr_valid = 1'b0;
    tick();
    app_ack = 1'b1; tick(); app_ack = 1'b0;
    n_tests++; if (app_en !== 1'b0) begin n_fail++; $display("FAIL iqfull_en: got %b want 0", app_en); end
    n_tests++; if (buf_count !== 5'd5) begin n_fail++; $display("FAIL iqfull_count: got %0d want 5", buf_count); end
    iq_full = 1'b0;
    tick();
    n_tests++; if ({app_en, app_instr} !== {1'b1, 32'h50}) begin n_fail++; $display("FAIL iqfull_release: got en=%b %h want 1 00000050", app_en, app_instr); end
    for (int k = 0; k < 5; k++) begin
      wait_app_en(ok);
      n_tests++; if (!ok || app_instr !== 32'h50 + 32'(k)) begin n_fail++; $display("FAIL iqfull_drain: ok=%b got %h want %h", ok, app_instr, 32'h50 + 32'(k)); end
      app_ack = 1'b1; tick(); app_ack = 1'b0;
    end
    n_tests++; if (buf_count !== 5'd0) begin n_fail++; $display("FAIL iqfull_empty: got %0d want 0", buf_count); end
  endtask

  task automatic test_full();
    bit ok;
    logic [31:0] exp;
    for (int i = 0; i < 16; i++) begin
      s_instr_valid = 1'b1; s_instr_data = 32'h100 + 32'(i);
      tick();
    end
    n_tests++; if ({s_instr_ready, buf_count} !== {1'b0, 5'd16}) begin n_fail++; $display("FAIL full_ready: got rdy=%b cnt=%0d want 0/16", s_instr_ready, buf_count); end
    s_instr_data = 32'h1FF;
    tick();
    n_tests++; if (buf_count !== 5'd16) begin n_fail++; $display("FAIL full_refuse: got %0d want 16", buf_count); end
    app_ack = 1'b1; tick(); app_ack = 1'b0;
    n_tests++; if (buf_count !== 5'd15) begin n_fail++; $display("FAIL full_push_pop: got %0d want 15", buf_count); end
    tick();
    s_instr_valid = 1'b0;
    n_tests++; if (buf_count !== 5'd16) begin n_fail++; $display("FAIL full_accept17: got %0d want 16", buf_count); end
    for (int k = 0; k < 16; k++) begin
      exp = (k < 15) ? 32'h101 + 32'(k) : 32'h1FF;
      wait_app_en(ok);
      n_tests++; if (!ok || app_instr !== exp) begin n_fail++; $display("FAIL full_drain: ok=%b got %h want %h", ok, app_instr, exp); end
      app_ack = 1'b1; tick(); app_ack = 1'b0;
    end
    n_tests++; if (buf_count !== 5'd0) begin n_fail++; $display("FAIL full_empty: got %0d want 0", buf_count); end
  endtask

  task automatic test_readback();
    logic [255:0] exp_d [4];
    logic         exp_pc [4];
    arr0[0] = 256'hA0; arr0[1] = 256'hA1; arr0[2] = 256'hA2;
    arr1[0] = 256'hB0; arr1[1] = 256'hB1;
    exp_d[0] = 256'hA0; exp_d[1] = 256'hB0; exp_d[2] = 256'hA1; exp_d[3] = 256'hB1;
    exp_pc[0] = 1'b0; exp_pc[1] = 1'b1; exp_pc[2] = 1'b0; exp_pc[3] = 1'b1;
    m_rd_ready = 1'b1; lim0 = 2; lim1 = 2;
    #1;
    n_tests++; if ({rd_en0, rd_en1} !== 2'b10) begin n_fail++; $display("FAIL rb_first_grant: got %b%b want 10", rd_en0, rd_en1); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++; if ({m_rd_valid, m_rd_pc, m_rd_data} !== {1'b1, exp_pc[k], exp_d[k]}) begin
        n_fail++; $display("FAIL rb_order[%0d]: got v=%b pc=%b %h want 1 %b %h", k, m_rd_valid, m_rd_pc, m_rd_data[15:0], exp_pc[k], exp_d[k][15:0]);
      end
      n_tests++; if ((rd_en0 && empty0) || (rd_en1 && empty1)) begin n_fail++; $display("FAIL rb_pop_empty: rd_en=%b%b empty=%b%b", rd_en0, rd_en1, empty0, empty1); end
    end
    m_rd_ready = 1'b0; lim0 = 3;
    #1;
    n_tests++; if ({rd_en0, rd_en1} !== 2'b00) begin n_fail++; $display("FAIL rb_stall_rden: got %b%b want 00", rd_en0, rd_en1); end
    tick(); tick();
    n_tests++; if ({m_rd_valid, m_rd_pc, m_rd_data} !== {1'b1, 1'b1, 256'hB1}) begin n_fail++; $display("FAIL rb_hold: got v=%b pc=%b %h want 1 1 b1", m_rd_valid, m_rd_pc, m_rd_data[15:0]); end
    n_tests++; if (pop0 !== 2) begin n_fail++; $display("FAIL rb_hold_pops: got %0d want 2", pop0); end
    m_rd_ready = 1'b1;
    tick();
    n_tests++; if ({m_rd_valid, m_rd_pc, m_rd_data} !== {1'b1, 1'b0, 256'hA2}) begin n_fail++; $display("FAIL rb_resume: got v=%b pc=%b %h want 1 0 a2", m_rd_valid, m_rd_pc, m_rd_data[15:0]); end
    tick();
    n_tests++; if (m_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rb_drained: got %b want 0", m_rd_valid); end
    m_rd_ready = 1'b0;
  endtask

  task automatic test_reset_mid_send();
    bit ok;
    for (int i = 0; i < 3; i++) begin
      s_instr_valid = 1'b1; s_instr_data = 32'h7700 + 32'(i);
      tick();
    end
    s_instr_valid = 1'b0;
    arr0[3] = 256'hA3; lim0 = 4;
    tick();
    n_tests++; if ({app_en, buf_count, m_rd_valid} !== {1'b1, 5'd3, 1'b1}) begin n_fail++; $display("FAIL rst_mid_pre: got en=%b cnt=%0d v=%b want 1/3/1", app_en, buf_count, m_rd_valid); end
    srst = 1'b1;
    tick();
    srst = 1'b0;
    n_tests++; if ({app_en, buf_count, m_rd_valid} !== {1'b0, 5'd0, 1'b0}) begin n_fail++; $display("FAIL rst_mid_post: got en=%b cnt=%0d v=%b want 0/0/0", app_en, buf_count, m_rd_valid); end
    n_tests++; if ({app_instr, m_rd_data} !== {32'h0, 256'h0}) begin n_fail++; $display("FAIL rst_mid_data: got instr=%h rd=%h want 0/0", app_instr, m_rd_data[15:0]); end
    s_instr_valid = 1'b1; s_instr_data = 32'hCAFE_F00D;
    tick();
    s_instr_valid = 1'b0;
    wait_app_en(ok);
    n_tests++; if (!ok || app_instr !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rst_mid_resume: ok=%b got %h want cafef00d", ok, app_instr); end
    app_ack = 1'b1; tick(); app_ack = 1'b0;
    n_tests++; if (buf_count !== 5'd0) begin n_fail++; $display("FAIL rst_mid_empty: got %0d want 0", buf_count); end
  endtask

  task automatic test_timeout();
    bit ok;
    int n_high;
    s_instr_valid = 1'b1; s_instr_data = 32'h0000_0007;
    tick();
    s_instr_valid = 1'b0;
    wait_app_en(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL to_launch: app_en never rose"); end
`ifdef SOFTMC_BRIDGE_TIMEOUT_EN
    n_high = 0;
    while (app_en === 1'b1 && n_high < 50) begin
      n_high++;
      tick();
    end
    n_tests++; if (n_high !== 8) begin n_fail++; $display("FAIL to_cycles: got %0d want 8", n_high); end
    n_tests++; if ({err_timeout, s_instr_ready, buf_count} !== {1'b1, 1'b0, 5'd1}) begin n_fail++; $display("FAIL to_err: got err=%b rdy=%b cnt=%0d want 1/0/1", err_timeout, s_instr_ready, buf_count); end
    arr1[2] = 256'hB2; lim1 = 3; m_rd_ready = 1'b1;
    tick();
    n_tests++; if ({m_rd_valid, m_rd_pc, m_rd_data} !== {1'b1, 1'b1, 256'hB2}) begin n_fail++; $display("FAIL to_drain: got v=%b pc=%b %h want 1 1 b2", m_rd_valid, m_rd_pc, m_rd_data[15:0]); end
    m_rd_ready = 1'b0;
    srst = 1'b1; tick(); srst = 1'b0;
    n_tests++; if ({err_timeout, s_instr_ready} !== 2'b01) begin n_fail++; $display("FAIL to_clear: got err=%b rdy=%b want 0/1", err_timeout, s_instr_ready); end
`else
    n_high = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (app_en !== 1'b1 || err_timeout !== 1'b0) n_high++;
    end
    n_tests++; if (n_high !== 0) begin n_fail++; $display("FAIL to_hold: %0d cycles dropped app_en or raised err, want 0", n_high); end
    n_tests++; if ({app_en, app_instr, err_timeout} !== {1'b1, 32'h7, 1'b0}) begin n_fail++; $display("FAIL to_final: got en=%b %h err=%b want 1 00000007 0", app_en, app_instr, err_timeout); end
    app_ack = 1'b1; tick(); app_ack = 1'b0;
    n_tests++; if ({app_en, buf_count} !== {1'b0, 5'd0}) begin n_fail++; $display("FAIL to_ack: got en=%b cnt=%0d want 0/0", app_en, buf_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_send_three();
    test_iq_full();
    test_full();
    test_readback();
    test_reset_mid_send();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
